// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate widths for the scan generator
// and the downstream bounds checkers.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int CNT_W = 10;

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-rate divider: o_tick is high for one clk out of every CLK_DIV clks
// (constantly high when CLK_DIV is 1).
module vga_pix_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic resetn,
  output logic o_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  assign o_tick = (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel coordinates, syncs, active video and strobes.
// Optional build macro VGA_SCAN_LOOKAHEAD_EN makes curr_x/curr_y/active lead the syncs by one tick.
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP
) (
  input  logic                   clk,
  input  logic                   resetn,
  output logic                   pix_en,
  output logic [vga_pkg::X_W-1:0] curr_x,
  output logic [vga_pkg::Y_W-1:0] curr_y,
  output logic                   active,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   line_start,
  output logic                   frame_start
);

  import vga_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic             w_tick;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic [CNT_W-1:0] w_h_nxt, w_v_nxt;
  logic [CNT_W-1:0] w_pos_h, w_pos_v;
  logic             w_h_last, w_v_last;
  logic             w_active, w_hsync, w_vsync;
  logic             w_wrap_h, w_wrap_v;
  logic             r_started;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
    .clk    (clk),
    .resetn (resetn),
    .o_tick (w_tick)
  );

  // The counters hold the position presented on the next pixel tick, so the
  // first tick after reset presents (0,0) and the wrap back to (0,0) is the
  // tick that carries the strobes.
  always_comb begin
    w_h_last = (r_h_cnt == H_LAST);
    w_v_last = (r_v_cnt == V_LAST);
    w_h_nxt  = w_h_last ? '0 : r_h_cnt + 1'b1;
    w_v_nxt  = r_v_cnt;
    if (w_h_last) begin
      w_v_nxt = w_v_last ? '0 : r_v_cnt + 1'b1;
    end
  end

`ifdef VGA_SCAN_LOOKAHEAD_EN
  assign w_pos_h = w_h_nxt;
  assign w_pos_v = w_v_nxt;
`else
  assign w_pos_h = r_h_cnt;
  assign w_pos_v = r_v_cnt;
`endif

  assign w_active = (w_pos_h < H_VIS) && (w_pos_v < V_VIS);
  assign w_hsync  = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vsync  = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

  // The very first (0,0) after reset is a start, not a wrap: no strobe.
  assign w_wrap_h = r_started && (r_h_cnt == '0);
  assign w_wrap_v = w_wrap_h && (r_v_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_started   <= 1'b0;
      pix_en      <= 1'b0;
      curr_x      <= '0;
      curr_y      <= '0;
      active      <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= w_tick;
      line_start  <= w_tick && w_wrap_h;
      frame_start <= w_tick && w_wrap_v;
      if (w_tick) begin
        r_started <= 1'b1;
        r_h_cnt   <= w_h_nxt;
        r_v_cnt   <= w_v_nxt;
        curr_x    <= w_active ? w_pos_h : '0;
        curr_y    <= w_active ? w_pos_v[Y_W-1:0] : '0;
        active    <= w_active;
        hsync     <= w_hsync;
        vsync     <= w_vsync;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen: a reduced-timing instance checked tick-by-tick via a
// scoreboard, plus a default-timing instance checked on its first line.
module tb_vga_scan_gen;

  localparam int CD = 2;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  localparam logic [24:0] RST_OUTS = {1'b0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;

  logic       pix_en, active, hsync, vsync, line_start, frame_start;
  logic [9:0] curr_x;
  logic [8:0] curr_y;

  logic       d_pix_en, d_active, d_hsync, d_vsync, d_line_start, d_frame_start;
  logic [9:0] d_curr_x;
  logic [8:0] d_curr_y;

  always #5 clk = ~clk;

  vga_scan_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .curr_x(curr_x), .curr_y(curr_y),
    .active(active), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_scan_gen dut_def (
    .clk(clk), .resetn(resetn), .pix_en(d_pix_en), .curr_x(d_curr_x), .curr_y(d_curr_y),
    .active(d_active), .hsync(d_hsync), .vsync(d_vsync),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  // Expected outputs for the k-th pixel tick after reset release.
  function automatic exp_t model(input int k);
    exp_t e;
    int p, x, y, pl, xl, yl;
    p = k % FT;
    x = p % HT;
    y = p / HT;
`ifdef VGA_SCAN_LOOKAHEAD_EN
    pl = (k + 1) % FT;
`else
    pl = p;
`endif
    xl = pl % HT;
    yl = pl / HT;
    e.act = (xl < HA) && (yl < VA);
    e.x   = e.act ? xl[9:0] : 10'd0;
    e.y   = e.act ? yl[8:0] : 9'd0;
    e.hs  = !((x >= HA + HF) && (x < HA + HF + HS));
    e.vs  = !((y >= VA + VF) && (y < VA + VF + VS));
    e.ls  = (k > 0) && (x == 0);
    e.fs  = (k > 0) && (p == 0);
    return e;
  endfunction

  task automatic push_ticks(input int from, input int n);
    for (int i = 0; i < n; i++) q.push_back(model(from + i));
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clk);
      #3;
      if (q.size() == 0) break;
    end
    check("drain", 64'(q.size()), 64'd0);
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor for the reduced-timing instance.
  int mon_k = 0;
  int gap = 0;
  int last_fs = -1;
  int act_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (!resetn) begin
      gap     = 0;
      last_fs = -1;
      act_cnt = 0;
      mon_k   = 0;
    end else begin
      gap++;
      if (pix_en) begin
        check("pix_en_spacing", 64'(gap), 64'(CD));
        gap = 0;
        if (q.size() == 0) begin
          check("spurious_pix_en", 64'(pix_en), 64'd0);
        end else begin
          e   = q.pop_front();
          got = {curr_x, curr_y, active, hsync, vsync, line_start, frame_start};
          check($sformatf("tick%0d", mon_k), 64'(got), 64'(e));
        end
        mon_k++;
        if (frame_start) begin
          if (last_fs >= 0) begin
            check("frame_period", 64'(cyc - last_fs), 64'(CD * FT));
            check("frame_active_cnt", 64'(act_cnt), 64'(HA * VA));
          end
          last_fs = cyc;
          act_cnt = 0;
        end
        if (active) act_cnt++;
      end else if (line_start || frame_start) begin
        check("strobe_off_tick", 64'({line_start, frame_start}), 64'd0);
      end
    end
  end

  // Event recorder for the first line of the default-timing instance.
  int         d_idx = 0;
  int         d_first_hs = -1;
  int         d_hs_low = 0;
  int         d_vs_low = 0;
  int         d_first_inact = -1;
  int         d_first_ls = -1;
  int         d_ls_cnt = 0;
  logic [9:0] d_x639 = '1;
  logic [9:0] d_x640 = '1;
  bit         d_done = 1'b0;

  always @(negedge clk) begin
    if (resetn && d_pix_en && !d_done) begin
      if (!d_hsync) begin
        if (d_first_hs < 0) d_first_hs = d_idx;
        d_hs_low++;
      end
      if (!d_vsync) d_vs_low++;
      if (!d_active && d_first_inact < 0) d_first_inact = d_idx;
      if (d_line_start) begin
        if (d_first_ls < 0) d_first_ls = d_idx;
        d_ls_cnt++;
      end
      if (d_idx == 639) d_x639 = d_curr_x;
      if (d_idx == 640) d_x640 = d_curr_x;
      d_idx++;
      if (d_idx == 820) d_done = 1'b1;
    end
  end

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_small", 64'({pix_en, curr_x, curr_y, active, hsync, vsync, line_start, frame_start}), 64'(RST_OUTS));
    check("rst_default", 64'({d_pix_en, d_curr_x, d_curr_y, d_active, d_hsync, d_vsync, d_line_start, d_frame_start}), 64'(RST_OUTS));

    // Five frames plus five lines and three pixels, then reset mid-frame.
    push_ticks(0, 5 * FT + 5 * HT + 3);
    @(negedge clk);
    #1 resetn = 1'b1;

    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #2;
      check($sformatf("d_pix_en_clk%0d", c), 64'(d_pix_en), 64'(c % 2 == 0));
      if (c == 2) begin
`ifdef VGA_SCAN_LOOKAHEAD_EN
        check("d_first_tick", 64'({d_curr_x, d_curr_y, d_active}), 64'({10'd1, 9'd0, 1'b1}));
`else
        check("d_first_tick", 64'({d_curr_x, d_curr_y, d_active}), 64'({10'd0, 9'd0, 1'b1}));
`endif
      end
    end

    wait_drain(4000);

    check("d_line_done", 64'(d_done), 64'd1);
    check("d_hsync_first_low", 64'(d_first_hs), 64'd656);
    check("d_hsync_low_ticks", 64'(d_hs_low), 64'd96);
    check("d_vsync_low_ticks", 64'(d_vs_low), 64'd0);
    check("d_line_start_idx", 64'(d_first_ls), 64'd800);
    check("d_line_start_cnt", 64'(d_ls_cnt), 64'd1);
    check("d_x_at_640", 64'(d_x640), 64'd0);
`ifdef VGA_SCAN_LOOKAHEAD_EN
    check("d_first_inactive", 64'(d_first_inact), 64'd639);
    check("d_x_at_639", 64'(d_x639), 64'd0);
`else
    check("d_first_inactive", 64'(d_first_inact), 64'd640);
    check("d_x_at_639", 64'(d_x639), 64'd639);
`endif

    // Mid-frame reset: outputs must drop to reset values at once.
    resetn = 1'b0;
    #1;
    check("midrst_small", 64'({pix_en, curr_x, curr_y, active, hsync, vsync, line_start, frame_start}), 64'(RST_OUTS));
    check("midrst_default", 64'({d_pix_en, d_curr_x, d_curr_y, d_active, d_hsync, d_vsync, d_line_start, d_frame_start}), 64'(RST_OUTS));
    repeat (3) @(posedge clk);
    #1;
    check("midrst_hold", 64'({pix_en, curr_x, curr_y, active, hsync, vsync, line_start, frame_start}), 64'(RST_OUTS));

    push_ticks(0, FT + 20);
    @(negedge clk);
    #1 resetn = 1'b1;
    wait_drain(1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
